// File: rtl/mbc_bus_arbiter.sv
// Cartridge bus arbiter: serves console ROM reads from a single-port memory, tracks the ROM bank register,
// and lets a loader write into the same memory while the bus is idle (loader arbitration under `MBC_LOADER_PORT_EN).
module mbc_bus_arbiter #(
    parameter int ROM_AW = 19
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              gb_rd,
    input  logic              gb_wr,
    input  logic [15:0]       gb_addr,
    input  logic [7:0]        gb_din,
    output logic [7:0]        gb_dout,
    output logic              gb_oe,
    input  logic              ld_req,
    input  logic [ROM_AW-1:0] ld_addr,
    input  logic [7:0]        ld_wdata,
    output logic              ld_gnt,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ROM_AW-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic [4:0]        bank
);

    typedef enum logic [1:0] {IDLE, RD_ISSUE, RD_WAIT, RD_HOLD} state_t;

    state_t      state_q, state_d;
    logic        rd_meta_q, rd_meta_d, rd_sync_q, rd_sync_d, rd_prev_q, rd_prev_d;
    logic        wr_meta_q, wr_meta_d, wr_sync_q, wr_sync_d, wr_prev_q, wr_prev_d;
    logic        rd_pend_q, rd_pend_d;
    logic [14:0] rd_addr_q, rd_addr_d;
    logic [4:0]  bank_q, bank_d;
    logic [7:0]  gb_dout_q, gb_dout_d;
    logic        gb_oe_q, gb_oe_d;

    logic rd_fall, wr_fall, rd_accept;
    logic unused_din;

    assign rd_fall    = rd_prev_q & ~rd_sync_q;
    assign wr_fall    = wr_prev_q & ~wr_sync_q;
    // Reads from the upper half of the map are not ROM and never become pending.
    assign rd_accept  = rd_fall & ~gb_addr[15];
    assign unused_din = ^gb_din[7:5];

`ifndef MBC_LOADER_PORT_EN
    logic unused_ld;
    assign unused_ld = ^{ld_req, ld_addr, ld_wdata};
`endif

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case leaves a latch.
        rd_meta_d = gb_rd;
        rd_sync_d = rd_meta_q;
        rd_prev_d = rd_sync_q;
        wr_meta_d = gb_wr;
        wr_sync_d = wr_meta_q;
        wr_prev_d = wr_sync_q;
        state_d   = state_q;
        rd_pend_d = rd_pend_q;
        rd_addr_d = rd_addr_q;
        bank_d    = bank_q;
        gb_dout_d = gb_dout_q;
        gb_oe_d   = gb_oe_q;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        ld_gnt    = 1'b0;

        if (wr_fall && gb_addr[15:13] == 3'b001) begin
            bank_d = (gb_din[4:0] == 5'd0) ? 5'd1 : gb_din[4:0];
        end

        case (state_q)
            IDLE: begin
                if (rd_pend_q) begin
                    rd_pend_d = 1'b0;
                    state_d   = RD_ISSUE;
                end
`ifdef MBC_LOADER_PORT_EN
                // A read detected this very cycle outranks the loader.
                else if (ld_req && !rd_accept) begin
                    mem_en    = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = ld_addr;
                    mem_wdata = ld_wdata;
                    ld_gnt    = 1'b1;
                end
`endif
            end
            RD_ISSUE: begin
                mem_en   = 1'b1;
                mem_addr = rd_addr_q[14] ? ROM_AW'({bank_q, rd_addr_q[13:0]})
                                         : ROM_AW'(rd_addr_q[13:0]);
                state_d  = RD_WAIT;
            end
            RD_WAIT: begin
                gb_dout_d = mem_rdata;
                gb_oe_d   = 1'b1;
                state_d   = RD_HOLD;
            end
            RD_HOLD: begin
                if (rd_sync_q) begin
                    gb_oe_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (rd_accept) begin
            rd_pend_d = 1'b1;
            rd_addr_d = gb_addr[14:0];
        end

        // Memory strobes are combinational, so they are forced quiet while reset is held.
        if (rst) begin
            mem_en    = 1'b0;
            mem_we    = 1'b0;
            mem_addr  = '0;
            mem_wdata = '0;
            ld_gnt    = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            rd_meta_q <= 1'b1;
            rd_sync_q <= 1'b1;
            rd_prev_q <= 1'b1;
            wr_meta_q <= 1'b1;
            wr_sync_q <= 1'b1;
            wr_prev_q <= 1'b1;
            rd_pend_q <= 1'b0;
            rd_addr_q <= '0;
            bank_q    <= 5'd1;
            gb_dout_q <= '0;
            gb_oe_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_meta_q <= rd_meta_d;
            rd_sync_q <= rd_sync_d;
            rd_prev_q <= rd_prev_d;
            wr_meta_q <= wr_meta_d;
            wr_sync_q <= wr_sync_d;
            wr_prev_q <= wr_prev_d;
            rd_pend_q <= rd_pend_d;
            rd_addr_q <= rd_addr_d;
            bank_q    <= bank_d;
            gb_dout_q <= gb_dout_d;
            gb_oe_q   <= gb_oe_d;
        end
    end

    assign gb_dout = gb_dout_q;
    assign gb_oe   = gb_oe_q;
    assign bank    = bank_q;

endmodule

// File: tb/tb_mbc_bus_arbiter.sv
// Directed bench for mbc_bus_arbiter: table of bus reads/writes plus hand sequences for reset, loader and arbitration.
module tb_mbc_bus_arbiter;

    localparam int AW = 19;

    logic          clk = 1'b0;
    logic          rst;
    logic          gb_rd, gb_wr;
    logic [15:0]   gb_addr;
    logic [7:0]    gb_din;
    logic [7:0]    gb_dout;
    logic          gb_oe;
    logic          ld_req;
    logic [AW-1:0] ld_addr;
    logic [7:0]    ld_wdata;
    logic          ld_gnt;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic [7:0]    mem_rdata = 8'h00;
    logic [4:0]    bank;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mbc_bus_arbiter #(.ROM_AW(AW)) dut (
        .clk(clk), .rst(rst), .gb_rd(gb_rd), .gb_wr(gb_wr), .gb_addr(gb_addr), .gb_din(gb_din),
        .gb_dout(gb_dout), .gb_oe(gb_oe), .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_gnt(ld_gnt), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .bank(bank)
    );

    // ROM model: content byte = low address byte + 0x73, one-cycle read latency.
    always @(posedge clk) begin
        if (mem_en && !mem_we) mem_rdata <= 8'(mem_addr[7:0] + 8'h73);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic          is_wr;
        logic [15:0]   addr;
        logic [7:0]    din;
        logic          accept;
        logic [4:0]    exp_bank;
        logic [AW-1:0] exp_maddr;
        logic [7:0]    exp_dout;
    } vec_t;

    vec_t vecs[11];

    task automatic do_write(input logic [15:0] addr, input logic [7:0] din);
        gb_addr = addr;
        gb_din  = din;
        gb_wr   = 1'b0;
        repeat (4) tick();
        gb_wr = 1'b1;
        repeat (4) tick();
    endtask

    task automatic do_read(input vec_t v);
        int            en_cnt;
        logic [AW-1:0] seen_addr;
        en_cnt    = 0;
        seen_addr = '0;
        gb_addr   = v.addr;
        gb_rd     = 1'b0;
        for (int i = 0; i < 12 && !gb_oe; i++) begin
            tick();
            if (mem_en) begin
                en_cnt++;
                seen_addr = mem_addr;
            end
        end
        if (v.accept) begin
            check("rd_en_cycles", en_cnt, 1);
            check("rd_mem_addr", seen_addr, v.exp_maddr);
            check("rd_oe", gb_oe, 1'b1);
            check("rd_dout", gb_dout, v.exp_dout);
            repeat (2) tick();
            check("rd_oe_held", gb_oe, 1'b1);
            gb_rd = 1'b1;
            repeat (2) tick();
            check("rd_oe_sync_hold", gb_oe, 1'b1);
            tick();
            check("rd_oe_release", gb_oe, 1'b0);
        end else begin
            check("rd_ign_en", en_cnt, 0);
            check("rd_ign_oe", gb_oe, 1'b0);
            gb_rd = 1'b1;
            repeat (4) tick();
        end
    endtask

    initial begin
        rst      = 1'b1;
        gb_rd    = 1'b1;
        gb_wr    = 1'b1;
        gb_addr  = '0;
        gb_din   = '0;
        ld_req   = 1'b0;
        ld_addr  = '0;
        ld_wdata = '0;

        //           wr    addr      din    acc   bank    maddr        dout
        vecs[0]  = '{1'b0, 16'h0150, 8'h00, 1'b1, 5'd1,  19'h00150, 8'hC3};
        vecs[1]  = '{1'b1, 16'h2100, 8'h00, 1'b0, 5'd1,  19'h00000, 8'h00};
        vecs[2]  = '{1'b1, 16'h2100, 8'h07, 1'b0, 5'd7,  19'h00000, 8'h00};
        vecs[3]  = '{1'b0, 16'h4010, 8'h00, 1'b1, 5'd7,  19'h1C010, 8'h83};
        vecs[4]  = '{1'b0, 16'hA000, 8'h00, 1'b0, 5'd7,  19'h00000, 8'h00};
        vecs[5]  = '{1'b1, 16'h6000, 8'h03, 1'b0, 5'd7,  19'h00000, 8'h00};
        vecs[6]  = '{1'b1, 16'h3FFF, 8'hFF, 1'b0, 5'h1F, 19'h00000, 8'h00};
        vecs[7]  = '{1'b0, 16'h7FFF, 8'h00, 1'b1, 5'h1F, 19'h7FFFF, 8'h72};
        vecs[8]  = '{1'b1, 16'h1FFF, 8'h05, 1'b0, 5'h1F, 19'h00000, 8'h00};
        vecs[9]  = '{1'b1, 16'h2000, 8'h22, 1'b0, 5'd2,  19'h00000, 8'h00};
        vecs[10] = '{1'b0, 16'h3FFF, 8'h00, 1'b1, 5'd2,  19'h03FFF, 8'h72};

        repeat (3) tick();
        check("rst_oe", gb_oe, 1'b0);
        check("rst_dout", gb_dout, 8'h00);
        check("rst_gnt", ld_gnt, 1'b0);
        check("rst_mem_en", mem_en, 1'b0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_mem_addr", mem_addr, '0);
        check("rst_mem_wdata", mem_wdata, 8'h00);
        check("rst_bank", bank, 5'd1);
        rst = 1'b0;
        repeat (2) tick();
        check("idle_mem_en", mem_en, 1'b0);

        for (int i = 0; i < 11; i++) begin
            if (vecs[i].is_wr) do_write(vecs[i].addr, vecs[i].din);
            else               do_read(vecs[i]);
            check($sformatf("vec%0d_bank", i), bank, vecs[i].exp_bank);
        end

        // Reset while the read data is being held on the bus.
        begin
            gb_addr = 16'h0150;
            gb_rd   = 1'b0;
            for (int i = 0; i < 12 && !gb_oe; i++) tick();
            check("mr_oe_before", gb_oe, 1'b1);
            rst   = 1'b1;
            gb_rd = 1'b1;
            tick();
            check("mr_oe_dropped", gb_oe, 1'b0);
            check("mr_bank", bank, 5'd1);
            check("mr_dout", gb_dout, 8'h00);
            repeat (2) tick();
            rst = 1'b0;
            for (int i = 0; i < 6; i++) begin
                tick();
                check("mr_discard", {gb_oe, mem_en}, 2'b00);
            end
        end

`ifdef MBC_LOADER_PORT_EN
        // Loader write while idle.
        ld_addr  = 19'h12345;
        ld_wdata = 8'hA5;
        ld_req   = 1'b1;
        #1;
        check("ld_gnt", ld_gnt, 1'b1);
        check("ld_mem_en", mem_en, 1'b1);
        check("ld_mem_we", mem_we, 1'b1);
        check("ld_mem_addr", mem_addr, 19'h12345);
        check("ld_mem_wdata", mem_wdata, 8'hA5);
        tick();
        ld_req = 1'b0;
        #1;
        check("ld_gnt_pulse", ld_gnt, 1'b0);
        check("ld_mem_en_off", mem_en, 1'b0);
        repeat (2) tick();

        // Loader request arriving in the same cycle as the read edge is detected.
        begin
            logic saw_read, oe_was, dropped, got_gnt, gnt_ok;
            saw_read = 1'b0;
            oe_was   = 1'b0;
            dropped  = 1'b0;
            got_gnt  = 1'b0;
            gnt_ok   = 1'b0;
            gb_addr  = 16'h0150;
            gb_rd    = 1'b0;
            repeat (2) tick();
            ld_addr  = 19'h00042;
            ld_wdata = 8'h5A;
            ld_req   = 1'b1;
            for (int i = 0; i < 40 && !got_gnt; i++) begin
                #1;
                if (mem_en && !mem_we) saw_read = 1'b1;
                if (gb_oe) begin
                    oe_was = 1'b1;
                    gb_rd  = 1'b1;
                end else if (oe_was) begin
                    dropped = 1'b1;
                end
                if (ld_gnt) begin
                    got_gnt = 1'b1;
                    gnt_ok  = saw_read && dropped && !gb_oe;
                    check("coinc_ld_addr", mem_addr, 19'h00042);
                end
                @(posedge clk);
            end
            #1;
            ld_req = 1'b0;
            gb_rd  = 1'b1;
            check("coinc_gnt_seen", got_gnt, 1'b1);
            check("coinc_read_first", gnt_ok, 1'b1);
            repeat (3) tick();
        end
`else
        // Loader port compiled out: requests must be ignored.
        ld_addr  = 19'h12345;
        ld_wdata = 8'hA5;
        ld_req   = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            check("noload_gnt", ld_gnt, 1'b0);
            check("noload_we", mem_we, 1'b0);
        end
        ld_req = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mbc_bus_arbiter.md
MBC_BUS_ARBITER -- requirements
Module: mbc_bus_arbiter

Interface
REQ-001 SHALL have parameter ROM_AW, default 19, ROM word-address width; bank bits = ROM_AW-14, where 5 banks bits are used and upper bits are zero-filled.
REQ-002 SHALL have port clk, input, 1, internal clock; the single clock of the block.
REQ-003 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-004 SHALL have port gb_rd, input, 1, cartridge read strobe, active low, asynchronous to clk.
REQ-005 SHALL have port gb_wr, input, 1, cartridge write strobe, active low, asynchronous to clk.
REQ-006 SHALL have port gb_addr, input, 16, cartridge address bus.
REQ-007 SHALL have port gb_din, input, 8, cartridge data bus toward the FPGA.
REQ-008 SHALL have port gb_dout, output, 8, read data toward the console.
REQ-009 SHALL have port gb_oe, output, 1, drive enable for gb_dout (1 = FPGA->GB).
REQ-010 SHALL have port ld_req, input, 1, loader write request (level).
REQ-011 SHALL have port ld_addr, input, ROM_AW, loader write address.
REQ-012 SHALL have port ld_wdata, input, 8, loader write data.
REQ-013 SHALL have port ld_gnt, output, 1, one-cycle pulse; the loader write was performed that cycle.
REQ-014 SHALL have ports mem_en, mem_we (1 each), mem_addr (ROM_AW), mem_wdata (8) as outputs and mem_rdata (8) as input: a single-port ROM memory with 1-cycle read latency.
REQ-015 SHALL have port bank, output, 5, current switchable bank number.

Function
REQ-016 SHALL pass gb_rd and gb_wr through 2-flop synchronizers; rd_fall and wr_fall are detected on the synchronized outputs.
REQ-017 SHALL capture gb_addr (and gb_din for writes) in the cycle the falling edge is detected.
REQ-018 SHALL hold a pending-read flag, set by rd_fall and cleared when the read is issued.
REQ-019 SHALL implement the FSM states IDLE, RD_ISSUE, RD_WAIT and RD_HOLD.
REQ-020 In IDLE, a pending read SHALL take priority and the FSM SHALL go to RD_ISSUE; otherwise, if ld_req=1, the block SHALL perform the loader write in that cycle and stay in IDLE.
REQ-021 A loader write SHALL assert mem_en=1, mem_we=1, mem_addr=ld_addr, mem_wdata=ld_wdata and ld_gnt=1 for exactly one cycle.
REQ-022 In RD_ISSUE, the block SHALL assert mem_en=1 and mem_we=0, and mem_addr SHALL be {0,addr[13:0]} if addr<0x4000, else {bank,addr[13:0]}; the FSM then goes to RD_WAIT.
REQ-023 In RD_WAIT, the block SHALL register gb_dout<=mem_rdata and set gb_oe=1, and the FSM goes to RD_HOLD.
REQ-024 In RD_HOLD, gb_dout and gb_oe SHALL be held until synchronized gb_rd=1, then gb_oe SHALL go to 0 and the FSM SHALL return to IDLE.
REQ-025 A read SHALL only be accepted when captured addr[15]=0; reads with addr[15]=1 SHALL be ignored, with no pending flag and no gb_oe.
REQ-026 On wr_fall with the captured address in 0x2000..0x3FFF, bank SHALL be set to din[4:0], and a value of 0 SHALL be written as 1; writes to any other address SHALL be ignored.
REQ-027 A bank write SHALL be independent of the FSM state and SHALL affect only reads issued after it.
REQ-028 A loader write SHALL never occur outside IDLE.
REQ-029 If rd_fall and ld_req coincide, the read SHALL win and the loader SHALL wait.
REQ-030 Outside any access, mem_en, mem_we and ld_gnt SHALL be 0.

Reset
REQ-031 While rst=1: FSM in IDLE; gb_oe=0, gb_dout=0x00, ld_gnt=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0; bank=1; pending flag cleared; synchronizers loaded with 1 (idle).
REQ-032 A reset asserted mid-read SHALL drop gb_oe in the cycle after rst is sampled, and that read SHALL be discarded.

Configuration
REQ-033 With MBC_LOADER_PORT_EN defined, the loader arbitration of REQ-020/021 SHALL be present.
REQ-034 Without MBC_LOADER_PORT_EN, ld_* inputs SHALL be ignored, ld_gnt SHALL be constant 0 and mem_we SHALL be constant 0.

Verification
REQ-035 The bench SHALL cover: reset, then gb_rd low with addr 0x0150 and mem_rdata=0xC3 -> mem_addr=0x00150 one cycle with mem_en=1, then gb_dout=0xC3 and gb_oe=1 until gb_rd high plus 2 syncing cycles.
REQ-036 The bench SHALL cover: gb_wr pulse with addr 0x2100 and din=0x00 -> bank=1; then din=0x07 -> bank=7; then a read at 0x4010 -> mem_addr=0x1C010.
REQ-037 The bench SHALL cover: ld_req=1 with ld_addr=0x12345 and ld_wdata=0xA5 in idle -> ld_gnt pulse with mem_we=1, mem_addr=0x12345, mem_wdata=0xA5.
REQ-038 The bench SHALL cover: rd_fall coinciding with ld_req=1 -> read issued first, and ld_gnt no earlier than the cycle after gb_oe drops.
REQ-039 The bench SHALL cover: a read at 0xA000 -> no mem_en and gb_oe stays 0; and rst=1 during RD_HOLD -> gb_oe=0 and bank=1 the next cycle.
REQ-040 The bench SHALL cover: a build without MBC_LOADER_PORT_EN driven with ld_req=1 for 100 cycles -> ld_gnt=0 and mem_we=0 throughout.
